// File: rtl/xadc_packet_package.sv
// Shared XADC packet definitions: frame length, header code and the depacketizer state encoding.
package xadc_packet_package;

  localparam int          XADC_PACKET_LENGTH                 = 4;
  localparam logic [3:0]  XADC_PACKET_HEADER_LOW_SPEED_SAMPLE = 4'h1;

  typedef enum logic [2:0] {
    BYTE0,
    BYTE1,
    BYTE2,
    BYTE3,
    EMIT,
    DISCARD
  } xadc_depacketizer_state_t;

endpackage

// File: rtl/xadc_depacketizer_sat_counter.sv
// Saturating event counter used for the depacketizer statistics.
module xadc_sat_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_q;

  // Holds at all-ones rather than wrapping, so a long error burst never reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/xadc_depacketizer.sv
// Rebuilds paired voltage/current XADC samples from 4-byte frames.
// Statistics counters exist only when XADC_DEPACKETIZER_STATS_EN is defined.
module xadc_depacketizer
  import xadc_packet_package::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             raw_tdata,
  input  logic                   raw_tvalid,
  output logic                   raw_tready,
  input  logic                   raw_tlast,
  output logic [15:0]            voltage_tdata,
  output logic                   voltage_tvalid,
  input  logic                   voltage_tready,
  output logic [15:0]            current_tdata,
  output logic                   current_tvalid,
  input  logic                   current_tready,
  output logic                   frame_error,
  output logic                   header_error,
  output logic [COUNT_WIDTH-1:0] packet_count,
  output logic [COUNT_WIDTH-1:0] frame_error_count,
  output logic [COUNT_WIDTH-1:0] header_error_count
);

  xadc_depacketizer_state_t state_q, state_d;
  logic [11:0] v_q, v_d;
  logic [11:0] i_q, i_d;
  logic        v_valid_q, v_valid_d;
  logic        i_valid_q, i_valid_d;
  logic        ready_q, ready_d;
  logic        frame_err_q, frame_err_d;
  logic        hdr_err_q, hdr_err_d;
  logic        accept;

  assign accept = raw_tvalid && ready_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    v_d         = v_q;
    i_d         = i_q;
    v_valid_d   = v_valid_q;
    i_valid_d   = i_valid_q;
    frame_err_d = 1'b0;
    hdr_err_d   = 1'b0;

    case (state_q)
      BYTE0: begin
        if (accept) begin
          if (raw_tdata[7:4] != XADC_PACKET_HEADER_LOW_SPEED_SAMPLE) begin
            hdr_err_d = 1'b1;
            state_d   = raw_tlast ? BYTE0 : DISCARD;
          end else if (raw_tlast) begin
            frame_err_d = 1'b1;
          end else begin
            v_d[11:8] = raw_tdata[3:0];
            state_d   = BYTE1;
          end
        end
      end
      BYTE1: begin
        if (accept) begin
          if (raw_tlast) begin
            frame_err_d = 1'b1;
            state_d     = BYTE0;
          end else begin
            v_d[7:0] = raw_tdata;
            state_d  = BYTE2;
          end
        end
      end
      BYTE2: begin
        if (accept) begin
          if (raw_tlast) begin
            frame_err_d = 1'b1;
            state_d     = BYTE0;
          end else begin
            i_d[11:8] = raw_tdata[3:0];
            state_d   = BYTE3;
          end
        end
      end
      BYTE3: begin
        if (accept) begin
          i_d[7:0] = raw_tdata;
          if (raw_tlast) begin
            v_valid_d = 1'b1;
            i_valid_d = 1'b1;
            state_d   = EMIT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = DISCARD;
          end
        end
      end
      EMIT: begin
        // Each stream retires on its own handshake; the frame ends when both have.
        v_valid_d = v_valid_q && !voltage_tready;
        i_valid_d = i_valid_q && !current_tready;
        if (!v_valid_d && !i_valid_d) begin
          state_d = BYTE0;
        end
      end
      DISCARD: begin
        if (accept && raw_tlast) begin
          state_d = BYTE0;
        end
      end
      default: state_d = BYTE0;
    endcase
  end

  // Registered so the port stays low through reset and rises one cycle after release.
  assign ready_d = (state_d != EMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BYTE0;
      v_q         <= '0;
      i_q         <= '0;
      v_valid_q   <= 1'b0;
      i_valid_q   <= 1'b0;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      i_q         <= i_d;
      v_valid_q   <= v_valid_d;
      i_valid_q   <= i_valid_d;
      ready_q     <= ready_d;
      frame_err_q <= frame_err_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign raw_tready     = ready_q;
  assign voltage_tdata  = 16'(v_q[SAMPLE_WIDTH-1:0]);
  assign current_tdata  = 16'(i_q[SAMPLE_WIDTH-1:0]);
  assign voltage_tvalid = v_valid_q;
  assign current_tvalid = i_valid_q;
  assign frame_error    = frame_err_q;
  assign header_error   = hdr_err_q;

`ifdef XADC_DEPACKETIZER_STATS_EN
  logic pkt_done;

  assign pkt_done = (state_q == EMIT) && !v_valid_d && !i_valid_d;

  xadc_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_packet_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_done),
    .count (packet_count)
  );

  xadc_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_frame_error_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_err_d),
    .count (frame_error_count)
  );

  xadc_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_header_error_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (hdr_err_d),
    .count (header_error_count)
  );
`else
  assign packet_count       = '0;
  assign frame_error_count  = '0;
  assign header_error_count = '0;
`endif

endmodule

// File: tb/tb_xadc_depacketizer.sv
// Scoreboard bench for xadc_depacketizer: directed frames drive queues, a negedge monitor checks outputs.
module tb_xadc_depacketizer;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    raw_tdata = '0;
  logic          raw_tvalid = 1'b0;
  logic          raw_tlast = 1'b0;
  logic          raw_tready;
  logic [15:0]   voltage_tdata, current_tdata;
  logic          voltage_tvalid, current_tvalid;
  logic          voltage_tready = 1'b1;
  logic          current_tready = 1'b1;
  logic          frame_error, header_error;
  logic [CW-1:0] packet_count, frame_error_count, header_error_count;

  xadc_depacketizer #(.SAMPLE_WIDTH(12), .COUNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .raw_tdata          (raw_tdata),
    .raw_tvalid         (raw_tvalid),
    .raw_tready         (raw_tready),
    .raw_tlast          (raw_tlast),
    .voltage_tdata      (voltage_tdata),
    .voltage_tvalid     (voltage_tvalid),
    .voltage_tready     (voltage_tready),
    .current_tdata      (current_tdata),
    .current_tvalid     (current_tvalid),
    .current_tready     (current_tready),
    .frame_error        (frame_error),
    .header_error       (header_error),
    .packet_count       (packet_count),
    .frame_error_count  (frame_error_count),
    .header_error_count (header_error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } samp_t;

  samp_t vq[$];
  samp_t iq[$];
  int    feq[$];
  int    heq[$];
  int    acc_cyc[8];
  int    pkt_exp = 0, fe_exp = 0, he_exp = 0;
  bit    v_prev = 1'b0, i_prev = 1'b0;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      v_prev = 1'b0;
      i_prev = 1'b0;
    end else begin
      if (voltage_tvalid) begin
        if (vq.size() == 0) begin
          check("voltage unexpected valid", vq.size(), 1);
        end else begin
          if (!v_prev) check("voltage latency", cyc, vq[0].cyc);
          check("voltage data", voltage_tdata, vq[0].data);
          if (voltage_tready) void'(vq.pop_front());
        end
      end
      if (current_tvalid) begin
        if (iq.size() == 0) begin
          check("current unexpected valid", iq.size(), 1);
        end else begin
          if (!i_prev) check("current latency", cyc, iq[0].cyc);
          check("current data", current_tdata, iq[0].data);
          if (current_tready) void'(iq.pop_front());
        end
      end
      if (frame_error) begin
        if (feq.size() == 0) check("frame_error unexpected", feq.size(), 1);
        else check("frame_error cycle", cyc, feq.pop_front());
      end
      if (header_error) begin
        if (heq.size() == 0) check("header_error unexpected", heq.size(), 1);
        else check("header_error cycle", cyc, heq.pop_front());
      end
      v_prev = voltage_tvalid && !voltage_tready;
      i_prev = current_tvalid && !current_tready;
    end
  end

  // Call with time just after a rising edge; returns likewise after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit last, output int acc);
    raw_tdata  = d;
    raw_tlast  = last;
    raw_tvalid = 1'b1;
    acc        = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (raw_tready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) check("raw_tready timeout", raw_tready, 1);
  endtask

  // Frame bytes packed MSB-first in f; fe_idx/he_idx mark the byte that must raise an error pulse.
  task automatic send_frame(input logic [63:0] f, input int n, input int fe_idx, input int he_idx,
                            input bit has_samp, input logic [15:0] v, input logic [15:0] i);
    int a;
    for (int k = 0; k < n; k++) begin
      send_byte(f[8*(n-1-k) +: 8], (k == n - 1), a);
      acc_cyc[k] = a;
      if (k == fe_idx) begin
        feq.push_back(a);
        if (fe_exp < 32'hFFFF) fe_exp++;
      end
      if (k == he_idx) begin
        heq.push_back(a);
        if (he_exp < 32'hFFFF) he_exp++;
      end
    end
    if (has_samp) begin
      vq.push_back('{data: v, cyc: acc_cyc[n-1]});
      iq.push_back('{data: i, cyc: acc_cyc[n-1]});
      pkt_exp++;
    end
    raw_tvalid = 1'b0;
    raw_tlast  = 1'b0;
  endtask

  task automatic good_frame(input logic [11:0] v, input logic [11:0] i);
    logic [63:0] f;
    f = {32'h0, 4'h1, v[11:8], v[7:0], 4'h0, i[11:8], i[7:0]};
    send_frame(f, 4, -1, -1, 1'b1, {4'h0, v}, {4'h0, i});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((vq.size() + iq.size() + feq.size() + heq.size()) != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) check("drain pending", vq.size() + iq.size() + feq.size() + heq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
`ifdef XADC_DEPACKETIZER_STATS_EN
    check("packet_count", packet_count, pkt_exp);
    check("frame_error_count", frame_error_count, fe_exp);
    check("header_error_count", header_error_count, he_exp);
`else
    check("packet_count tied", packet_count, 0);
    check("frame_error_count tied", frame_error_count, 0);
    check("header_error_count tied", header_error_count, 0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " raw_tready"}, raw_tready, 0);
    check({tag, " voltage_tvalid"}, voltage_tvalid, 0);
    check({tag, " current_tvalid"}, current_tvalid, 0);
    check({tag, " voltage_tdata"}, voltage_tdata, 0);
    check({tag, " current_tdata"}, current_tdata, 0);
    check({tag, " frame_error"}, frame_error, 0);
    check({tag, " header_error"}, header_error, 0);
    check({tag, " packet_count"}, packet_count, 0);
    check({tag, " frame_error_count"}, frame_error_count, 0);
    check({tag, " header_error_count"}, header_error_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, f2, a;

    // Reset values, then ready must rise on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("ready before first edge", raw_tready, 0);
    @(posedge clk);
    #1;
    check("ready after first edge", raw_tready, 1);

    // Good frame 1A BC 03 45.
    good_frame(12'hABC, 12'h345);
    drain();
    check_counts();

    // Bad header, frame discarded through tlast, then a clean frame.
    send_frame(64'h2A11_2233, 4, -1, 0, 1'b0, 16'h0, 16'h0);
    good_frame(12'h123, 12'h456);
    drain();
    check_counts();

    // Short frame, then 10 01 00 02.
    send_frame(64'h1122, 2, 1, -1, 1'b0, 16'h0, 16'h0);
    good_frame(12'h001, 12'h002);
    drain();
    check_counts();

    // Long frame: error after byte 4, bytes 5-6 dropped.
    send_frame(64'h1FFF_0FEE_5566, 6, 3, -1, 1'b0, 16'h0, 16'h0);
    drain();
    check_counts();

    // Single-byte frames: good header with tlast, bad header with tlast; B2 upper nibble ignored.
    send_frame(64'h15, 1, 0, -1, 1'b0, 16'h0, 16'h0);
    send_frame(64'h2F, 1, -1, 0, 1'b0, 16'h0, 16'h0);
    send_frame(64'h1ABC_F345, 4, -1, -1, 1'b1, 16'h0ABC, 16'h0345);
    drain();
    check_counts();

    // Back-to-back frames: one packet per five cycles.
    good_frame(12'h7E1, 12'h18F);
    f1 = acc_cyc[0];
    good_frame(12'h2B2, 12'hFFF);
    f2 = acc_cyc[0];
    check("throughput B0 spacing", f2 - f1, 5);
    drain();
    check_counts();

    // Current backpressure during EMIT.
    current_tready = 1'b0;
    good_frame(12'hC34, 12'hD56);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("raw_tready low in EMIT", raw_tready, 0);
      @(posedge clk);
      #1;
    end
    current_tready = 1'b1;
    @(negedge clk);
    check("raw_tready at current handshake", raw_tready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("raw_tready after current handshake", raw_tready, 1);
    @(posedge clk);
    #1;
    drain();
    check_counts();

`ifdef XADC_DEPACKETIZER_STATS_EN
    // Header error counter saturation.
    for (int k = 0; k < 65540; k++) begin
      send_frame(64'h2F, 1, -1, 0, 1'b0, 16'h0, 16'h0);
    end
    drain();
    check("header_error_count saturated", header_error_count, 16'hFFFF);
    check_counts();
`endif

    // Reset mid-frame after B1.
    send_byte(8'h1A, 1'b0, a);
    send_byte(8'hBC, 1'b0, a);
    raw_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("mid-frame reset");
    pkt_exp = 0;
    fe_exp  = 0;
    he_exp  = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    good_frame(12'h5A5, 12'h0F0);
    drain();
    check_counts();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
